// File: rtl/univ_shift_reg_n.sv
// rtl/univ_shift_reg_n.sv - parametrised universal shift register with counted burst engine
//
// Purpose: WIDTH-bit universal shift register with hold/shift/load/rotate/arithmetic ops and a
//          burst engine that applies one op CNT times under a START/BUSY/DONE handshake.
// Ports:
//   CLK    clock, all state updates on posedge
//   CLRb   asynchronous active-low reset
//   EN     clock enable; 0 freezes Q and stalls a burst
//   S      op select: 000/100 hold, 001 lsr, 010 lsl, 011 load, 101 ror, 110 rol, 111 asr
//   SDL    serial in to LSB on left shift
//   SDR    serial in to MSB on logical right shift
//   D      parallel load data
//   START  begin a burst of CNT ops of type S
//   CNT    burst length
//   Q      register contents
//   SOL    Q[WIDTH-1]
//   SOR    Q[0]
//   BUSY   burst in progress
//   DONE   one-cycle pulse when a burst completes
// Build option: UNIV_SHIFT_BARREL_EN - bursts complete in one cycle through a barrel shifter.

module univ_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             CLRb,
  input  logic             EN,
  input  logic [2:0]       S,
  input  logic             SDL,
  input  logic             SDR,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic [CNT_W-1:0] CNT,
  output logic [WIDTH-1:0] Q,
  output logic             SOL,
  output logic             SOR,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_r, state_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic [CNT_W-1:0] rem_r, rem_nxt;
  logic [2:0]       op_r, op_nxt;
  logic             done_r, done_nxt;

  // START requests that never enter the counted engine.
  logic start_null;
  logic start_load;
  logic start_single;

  assign start_null   = (CNT == '0) || (S[1:0] == 2'b00);
  assign start_load   = (S == 3'b011);
  assign start_single = (CNT == CNT_W'(1));

  // Single application of an op.
  function automatic logic [WIDTH-1:0] step_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d,
    input logic             sdl,
    input logic             sdr
  );
    logic [WIDTH-1:0] r;
    case (op)
      3'b001:  r = {sdr, q[WIDTH-1:1]};
      3'b010:  r = {q[WIDTH-2:0], sdl};
      3'b011:  r = d;
      3'b101:  r = {q[0], q[WIDTH-1:1]};
      3'b110:  r = {q[WIDTH-2:0], q[WIDTH-1]};
      3'b111:  r = {q[WIDTH-1], q[WIDTH-1:1]};
      default: r = q;
    endcase
    return r;
  endfunction

`ifdef UNIV_SHIFT_BARREL_EN
  // N-fold application in one step. The operand is paired with its fill word (or with itself
  // for rotates) and shifted as a double-width vector, so the bits entering the kept half are
  // exactly the fill bits. Logical/arithmetic amounts saturate at WIDTH; rotates use N mod WIDTH.
  function automatic logic [WIDTH-1:0] barrel_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] q,
    input logic [CNT_W-1:0] n,
    input logic             sdl,
    input logic             sdr
  );
    logic [2*WIDTH-1:0] wide;
    logic [WIDTH-1:0]   r;
    int                 amt;
    int                 rot;
    amt  = (int'(n) >= WIDTH) ? WIDTH : int'(n);
    rot  = int'(n) % WIDTH;
    wide = {q, q};
    r    = q;
    case (op)
      3'b001: begin
        wide = {{WIDTH{sdr}}, q} >> amt;
        r    = wide[WIDTH-1:0];
      end
      3'b010: begin
        wide = {q, {WIDTH{sdl}}} << amt;
        r    = wide[2*WIDTH-1:WIDTH];
      end
      3'b101: begin
        wide = {q, q} >> rot;
        r    = wide[WIDTH-1:0];
      end
      3'b110: begin
        wide = {q, q} << rot;
        r    = wide[2*WIDTH-1:WIDTH];
      end
      3'b111: begin
        wide = {{WIDTH{q[WIDTH-1]}}, q} >> amt;
        r    = wide[WIDTH-1:0];
      end
      default: r = q;
    endcase
    return r;
  endfunction
`endif

  // State register
  always_ff @(posedge CLK or negedge CLRb) begin
    if (!CLRb) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
`ifndef UNIV_SHIFT_BARREL_EN
        if (EN && START && !start_null && !start_load && !start_single) begin
          state_nxt = ST_RUN;
        end
`endif
      end
      ST_RUN: begin
        // rem_r==1 means this edge applies the final op.
        if (EN && (rem_r == CNT_W'(1))) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    q_nxt    = q_r;
    rem_nxt  = rem_r;
    op_nxt   = op_r;
    done_nxt = 1'b0;
    if (EN) begin
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            if (start_null) begin
              done_nxt = 1'b1;
            end else if (start_load) begin
              q_nxt    = D;
              done_nxt = 1'b1;
            end else begin
              op_nxt = S;
`ifdef UNIV_SHIFT_BARREL_EN
              q_nxt    = barrel_op(S, q_r, CNT, SDL, SDR);
              rem_nxt  = '0;
              done_nxt = 1'b1;
`else
              // First op is applied on the START edge itself.
              q_nxt    = step_op(S, q_r, D, SDL, SDR);
              rem_nxt  = CNT - CNT_W'(1);
              done_nxt = start_single;
`endif
            end
          end else begin
            q_nxt = step_op(S, q_r, D, SDL, SDR);
          end
        end
        ST_RUN: begin
          q_nxt    = step_op(op_r, q_r, D, SDL, SDR);
          rem_nxt  = rem_r - CNT_W'(1);
          done_nxt = (rem_r == CNT_W'(1));
        end
        default: begin
          q_nxt = q_r;
        end
      endcase
    end
  end

  // Datapath registers; DONE is cleared every cycle so it stays a single-cycle pulse.
  always_ff @(posedge CLK or negedge CLRb) begin
    if (!CLRb) begin
      q_r    <= '0;
      rem_r  <= '0;
      op_r   <= 3'b000;
      done_r <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      rem_r  <= rem_nxt;
      op_r   <= op_nxt;
      done_r <= done_nxt;
    end
  end

  assign Q    = q_r;
  assign SOL  = q_r[WIDTH-1];
  assign SOR  = q_r[0];
  assign BUSY = (state_r == ST_RUN);
  assign DONE = done_r;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// tb/tb_univ_shift_reg_n.sv - self-checking bench for univ_shift_reg_n
module tb_univ_shift_reg_n;

  localparam int W  = 8;
  localparam int CW = 4;
`ifdef UNIV_SHIFT_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MSB = ONE << (W - 1);

  logic          CLK;
  logic          CLRb;
  logic          EN;
  logic [2:0]    S;
  logic          SDL;
  logic          SDR;
  logic [W-1:0]  D;
  logic          START;
  logic [CW-1:0] CNT;
  logic [W-1:0]  Q;
  logic          SOL;
  logic          SOR;
  logic          BUSY;
  logic          DONE;

  int checks = 0;
  int errors = 0;

  // Reference state: register value, ops still owed by an active burst, burst op, DONE.
  typedef struct packed {
    logic [W-1:0] q;
    logic [CW:0]  left;
    logic [2:0]   op;
    logic         done;
  } mstate_t;

  mstate_t m;

  univ_shift_reg_n #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK   (CLK),
    .CLRb  (CLRb),
    .EN    (EN),
    .S     (S),
    .SDL   (SDL),
    .SDR   (SDR),
    .D     (D),
    .START (START),
    .CNT   (CNT),
    .Q     (Q),
    .SOL   (SOL),
    .SOR   (SOR),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One op, in arithmetic form.
  function automatic logic [W-1:0] op1(input logic [2:0] op, input logic [W-1:0] q,
                                       input logic [W-1:0] d, input logic sl, input logic sr);
    case (op)
      3'd1:    return (q >> 1) | (sr ? MSB : '0);
      3'd2:    return (q << 1) | (sl ? ONE : '0);
      3'd3:    return d;
      3'd5:    return (q >> 1) | (q[0] ? MSB : '0);
      3'd6:    return (q << 1) | (q[W-1] ? ONE : '0);
      3'd7:    return (q >> 1) | (q & MSB);
      default: return q;
    endcase
  endfunction

  function automatic mstate_t model_next(input mstate_t c, input logic en, input logic st,
                                         input logic [2:0] s, input logic [CW-1:0] cnt,
                                         input logic [W-1:0] d, input logic sl, input logic sr);
    mstate_t n;
    n      = c;
    n.done = 1'b0;
    if (en) begin
      if (c.left != 0) begin
        n.q    = op1(c.op, c.q, d, sl, sr);
        n.left = c.left - 1'b1;
        n.done = (n.left == 0);
      end else if (st) begin
        if (cnt == 0 || s == 3'd0 || s == 3'd4) begin
          n.done = 1'b1;
        end else if (s == 3'd3) begin
          n.q    = d;
          n.done = 1'b1;
        end else if (BARREL) begin
          n.op = s;
          for (int i = 0; i < int'(cnt); i++) n.q = op1(s, n.q, d, sl, sr);
          n.done = 1'b1;
        end else begin
          n.op   = s;
          n.q    = op1(s, c.q, d, sl, sr);
          n.left = {1'b0, cnt} - 1'b1;
          n.done = (cnt == 1);
        end
      end else begin
        n.q = op1(s, c.q, d, sl, sr);
      end
    end
    return n;
  endfunction

  always @(posedge CLK or negedge CLRb) begin
    if (!CLRb) m <= '0;
    else       m <= model_next(m, EN, START, S, CNT, D, SDL, SDR);
  end

  task automatic chkq(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the reference.
  task automatic sample();
    @(negedge CLK);
    chkq("q", Q, m.q);
    chkb("busy", BUSY, m.left != 0);
    chkb("done", DONE, m.done);
    chkb("sol", SOL, m.q[W-1]);
    chkb("sor", SOR, m.q[0]);
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  // Issue a burst and count cycles from the START edge until DONE is seen.
  task automatic run_burst(input logic [2:0] s, input logic [CW-1:0] cnt, input logic sl,
                           input logic sr, input int stall_lo, input int stall_hi,
                           input bit inject, output int k, output int busy_n);
    bit found;
    found = 1'b0;
    S = s; CNT = cnt; SDL = sl; SDR = sr; START = 1'b1; EN = 1'b1;
    cyc();
    START = 1'b0; S = 3'd0;
    k = 1; busy_n = 0;
    for (int g = 0; g < 40 && !found; g++) begin
      sample();
      if (DONE) begin
        found = 1'b1;
      end else begin
        if (BUSY) busy_n++;
        EN = !(k >= stall_lo && k <= stall_hi);
        if (inject && k == 1) begin
          START = 1'b1; S = 3'd2; CNT = 4'd5;
        end else begin
          START = 1'b0; S = 3'd0;
        end
        adv();
        k++;
      end
    end
    EN = 1'b1; START = 1'b0; S = 3'd0;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL burst_timeout: got no DONE expected DONE within 40 cycles");
    end
    adv();
  endtask

  initial begin
    int k, bn, nd;
    CLRb = 1'b1; EN = 1'b0; S = 3'd0; SDL = 1'b0; SDR = 1'b0;
    D = '0; START = 1'b0; CNT = '0;
    #1 CLRb = 1'b0;
    adv(); adv();
    sample();
    chkq("rst_q", Q, 8'h00);
    chkb("rst_busy", BUSY, 1'b0);
    chkb("rst_done", DONE, 1'b0);
    adv();
    CLRb = 1'b1; EN = 1'b1;

    // Reset / load
    S = 3'd3; D = 8'h3C; cyc(); S = 3'd0;
    chkq("pre_rst_load", Q, 8'h3C);
    CLRb = 1'b0;
    #1 chkq("async_clr_q", Q, 8'h00);
    chkq("async_clr_model", m.q, 8'h00);
    #1 CLRb = 1'b1;
    S = 3'd3; D = 8'hA5; cyc(); S = 3'd0;
    chkq("load_a5", Q, 8'hA5);
    chkq("load_a5_model", m.q, 8'hA5);

    // Legacy shifts
    S = 3'd3; D = 8'h81; cyc();
    S = 3'd2; SDL = 1'b1; cyc();
    chkq("legacy_left", Q, 8'h03);
    S = 3'd1; SDR = 1'b0; SDL = 1'b0; cyc();
    chkq("legacy_right", Q, 8'h01);
    S = 3'd0;

    // Burst rotate left x3, with a START injected while running
    S = 3'd3; D = 8'h81; cyc();
    run_burst(3'd6, 4'd3, 1'b0, 1'b0, 99, 99, 1'b1, k, bn);
    chkq("rot_q", Q, 8'h0C);
    chki("rot_latency", k, BARREL ? 1 : 3);
    chki("rot_busy_cycles", bn, BARREL ? 0 : 2);

    // Arithmetic right x4 with two stalled cycles
    S = 3'd3; D = 8'h80; cyc();
    run_burst(3'd7, 4'd4, 1'b0, 1'b0, 2, 3, 1'b0, k, bn);
    chkq("asr_q", Q, 8'hF8);
    chki("asr_latency", k, BARREL ? 1 : 6);

    // CNT=0: no change, single DONE
    S = 3'd3; D = 8'h5A; cyc();
    S = 3'd2; SDL = 1'b1; CNT = '0; START = 1'b1; cyc();
    START = 1'b0; S = 3'd0;
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      if (DONE) nd++;
      adv();
    end
    chki("cnt0_done_pulses", nd, 1);
    chkq("cnt0_q", Q, 8'h5A);

    // Left x9 with SDL=1 beyond WIDTH
    S = 3'd3; D = 8'h00; cyc();
    run_burst(3'd2, 4'd9, 1'b1, 1'b0, 99, 99, 1'b0, k, bn);
    chkq("left9_q", Q, 8'hFF);
    chki("left9_latency", k, BARREL ? 1 : 9);
    SDL = 1'b0;

    // Reset mid-burst
    S = 3'd3; D = 8'hF0; cyc();
    S = 3'd1; SDR = 1'b1; CNT = 4'd8; START = 1'b1; cyc();
    START = 1'b0; S = 3'd0;
    cyc(); cyc();
    CLRb = 1'b0;
    #1 chkq("midrst_q", Q, 8'h00);
    chkb("midrst_busy", BUSY, 1'b0);
    #1 CLRb = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      sample();
      if (DONE) nd++;
      adv();
    end
    chki("midrst_no_done", nd, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      EN    = ($urandom_range(7) != 0);
      S     = 3'($urandom_range(7));
      SDL   = 1'($urandom_range(1));
      SDR   = 1'($urandom_range(1));
      D     = W'($urandom);
      CNT   = CW'($urandom);
      START = ($urandom_range(5) == 0);
      if ($urandom_range(399) == 0) begin
        CLRb = 1'b0;
        cyc();
        CLRb = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg_n.md
Name: univ_shift_reg_n

Overview:
- Parametrised universal shift register; next generation of the 4-bit universal shift register.
- Keeps the 2-bit hold/shift-left/shift-right/load encoding in S[1:0].
- Adds rotate and arithmetic-right modes, a clock enable, and serial-out taps.
- Adds a counted "burst" shift engine (START/BUSY/DONE) that applies one operation N times without host sequencing.
- Used as the datapath register for serial links and shift/multiply exercises.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- CNT_W, 4, width of burst count input CNT.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- CLRb  input  1  asynchronous active-low reset.
- EN  input  1  clock enable; 0 freezes Q and stalls any burst.
- S  input  3  operation select (see Behaviour).
- SDL  input  1  serial data into LSB on left shift.
- SDR  input  1  serial data into MSB on logical right shift.
- D  input  WIDTH  parallel load data.
- START  input  1  begin burst of CNT operations of type S.
- CNT  input  CNT_W  burst length.
- Q  output  WIDTH  register contents.
- SOL  output  1  Q[WIDTH-1] (bit lost on next left shift), combinational.
- SOR  output  1  Q[0] (bit lost on next right shift), combinational.
- BUSY  output  1  burst in progress.
- DONE  output  1  one-cycle pulse, burst complete.

Behaviour:
- Reset: CLRb=0 asynchronously forces Q=0, BUSY=0, DONE=0, state=IDLE, remaining count=0, latched op=000. Reset mid-burst aborts the burst with no DONE.
- Op encoding (per applied cycle):
  - 000 hold.
  - 001 logical right: Q <= {SDR, Q[W-1:1]}.
  - 010 left: Q <= {Q[W-2:0], SDL}.
  - 011 load: Q <= D.
  - 100 hold.
  - 101 rotate right: {Q[0], Q[W-1:1]}.
  - 110 rotate left: {Q[W-2:0], Q[W-1]}.
  - 111 arithmetic right: {Q[W-1], Q[W-1:1]}.
- S=0xx is bit-compatible with the 4-bit block.
- FSM states: IDLE, RUN.
- IDLE, START=0, EN=1: apply S every cycle. EN=0: hold.
- IDLE, START=1, EN=1:
  - CNT=0 or S∈{000,100}: no change to Q; DONE=1 next cycle; stay IDLE.
  - S=011: load D once; DONE=1 next cycle; stay IDLE.
  - Otherwise: latch S into op_r; apply op once this edge; rem <= CNT-1. If CNT=1, DONE next cycle and stay IDLE; else go to RUN, BUSY=1.
- START with EN=0 is ignored.
- RUN:
  - Each cycle with EN=1: apply op_r, rem <= rem-1.
  - When the edge applying the final op occurs (rem=1), go to IDLE; BUSY=0 and DONE=1 in the following cycle, coincident with the final Q.
  - EN=0: Q, rem and state frozen; BUSY stays 1.
  - S, D and START are ignored; SDL/SDR are sampled live every applied cycle.
- Latency: burst of N≥1 completes with DONE high exactly N cycles after the START edge, given EN held 1.
- DONE is registered, high for exactly 1 cycle, never with BUSY=1.

Optional Feature:
- Macro: UNIV_SHIFT_BARREL_EN.
- Defined: bursts finish in a single cycle via a barrel shifter. BUSY is never asserted. Q holds the N-fold result and DONE=1 the cycle after START.
  - Fill bits are SDL/SDR sampled at START, replicated.
  - Logical shifts with N≥WIDTH yield all fill bits.
  - Arithmetic right with N≥WIDTH yields all sign bits.
  - Rotates use N mod WIDTH.
- Undefined: one bit per cycle as above; the RUN state and BUSY logic are present.

Test Plan (WIDTH=8, CNT_W=4):
- Reset/load: CLRb pulse low mid-cycle -> Q=00 immediately. Then S=011, D=A5, EN=1 -> Q=A5 next edge.
- Legacy compatibility: Q=81, S=010, SDL=1, 1 cycle -> Q=03. Then S=001, SDR=0 -> Q=01.
- Burst rotate: Q=81, START with S=110, CNT=3 -> BUSY for 2 cycles, Q=0C, DONE pulse at cycle 3; with barrel macro, Q=0C and DONE after 1 cycle.
- Arithmetic burst with stall: Q=80, START with S=111, CNT=4, EN=0 for 2 mid-burst cycles -> Q=F8, DONE 6 cycles after START.
- Boundaries: START with CNT=0 -> Q unchanged, single DONE. START during RUN -> ignored. Barrel macro with S=010, CNT=9, SDL=1 -> Q=FF.
- Reset mid-burst: CLRb low during RUN -> Q=00, BUSY=0, and no DONE pulse afterwards.
